bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using shift-add-3 (double-dabble), one input bit per clock.
- Generalises the calculator's fixed 4-bit combinational converter to any input width and digit count.
- Adds a start/busy/done handshake and overflow detection.
- Sits between the calculator ALU result register and the seven-segment digit mux.

Parameters:
- BIN_W, 8, binary input width in bits (>= 2).
- DIGITS, 3, number of BCD output digits (>= 1); bcd_out is 4*DIGITS bits wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request conversion of bin_in; sampled only when busy=0.
- bin_in  in  BIN_W  binary operand; captured on the accepting edge only.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse; result valid.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0]; holds the last result.
- ovf  out  1  result exceeded DIGITS digits; valid with done, held with bcd_out.
- sign_out  out  1  sign of the last result (see Optional Feature); held with bcd_out.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, bcd_out=0, ovf=0, sign_out=0; internal shift register and counter cleared.
  - Reset during SHIFT aborts the conversion; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> load shift register {DIGITS*4 zeros, operand}; counter=BIN_W; clear internal ovf accumulator; go SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT: busy=1. Each cycle:
  - Every digit whose value is >= 5 gets +3 (all digits in parallel, combinational).
  - Then shift the whole register left by 1; the binary MSB enters digit 0 bit 0.
  - If bit 3 of the top digit is 1 before the shift, set the internal ovf accumulator (sticky).
  - Decrement counter; when counter reaches 1 in this cycle, go DONE.
- DONE: done=1 for exactly this cycle.
  - bcd_out, ovf and sign_out update on the edge entering DONE and hold until the next DONE.
  - busy=0, so start=1 in DONE is accepted exactly as in IDLE (back-to-back conversions).
  - Otherwise return to IDLE.
- Latency: start sampled at edge N -> done high in the cycle after edge N+BIN_W (BIN_W+1 clocks). Throughput: one conversion per BIN_W+1 clocks.
- start while busy=1 is ignored, and bin_in changes while busy have no effect.
- Overflow case: DIGITS too small for 2^BIN_W-1. bcd_out holds the low DIGITS digits (truncated), and ovf=1.
- Digit-value invariant: no digit of bcd_out ever exceeds 9, with or without overflow.

Optional Feature:
- Macro: BIN_TO_BCD_SIGNED_EN.
- Defined:
  - bin_in is two's complement.
  - On acceptance, if bin_in[BIN_W-1]=1 the operand is -bin_in (unsigned BIN_W-bit magnitude) and the sign is latched as 1.
  - sign_out presents the latched sign with done.
  - Most-negative input (-2^(BIN_W-1)) converts to magnitude 2^(BIN_W-1) with sign_out=1.
  - Zero always gives sign_out=0.
- Not defined: bin_in is unsigned and sign_out is constant 0. Port list is identical in both builds.

Test Plan:
- BIN_W=8, DIGITS=3, unsigned: bin_in=0, start pulse -> done 9 clocks later; bcd_out=12'h000, ovf=0.
- bin_in=8'd255 -> bcd_out=12'h255, ovf=0; busy high exactly 8 cycles; done high exactly 1 cycle.
- Start 8'd99, then pulse start with 8'd42 at cycle 3 while busy -> ignored; result 12'h099. Then assert start in the DONE cycle with 8'd42 -> next result 12'h042 with no idle gap.
- rst pulse mid-SHIFT (cycle 4 of 8) -> all outputs 0 immediately, no done. Then convert 8'd128 -> 12'h128.
- DIGITS=2, BIN_W=8: bin_in=8'd200 -> ovf=1, bcd_out=8'h00. bin_in=8'd99 -> ovf=0, bcd_out=8'h99.
- BIN_TO_BCD_SIGNED_EN defined: 8'h80 -> sign_out=1, bcd_out=12'h128. 8'hFF -> sign_out=1, 12'h001. 8'h7F -> sign_out=0, 12'h127.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Start/busy/done handshake with sticky overflow when the value needs more
// than DIGITS digits; bcd_out then holds the truncated low digits.
// Optional build macro BIN_TO_BCD_SIGNED_EN: treat bin_in as two's complement,
// convert its magnitude and report the sign on sign_out (constant 0 otherwise).
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  sign_out
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + BIN_W;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q;
  logic [SrW-1:0]      sr_q;
  logic [SrW-1:0]      sr_adj;
  logic [SrW-1:0]      sr_shift;
  logic [CntW-1:0]     cnt_q;
  logic                ovf_acc_q;
  logic                sign_q;
  logic [BIN_W-1:0]    operand;
  logic                operand_sign;

  // Operand selection: magnitude and sign of the accepted input
`ifdef BIN_TO_BCD_SIGNED_EN
  always_comb begin
    operand_sign = bin_in[BIN_W-1];
    operand      = operand_sign ? (~bin_in + 1'b1) : bin_in;
  end
`else
  always_comb begin
    operand_sign = 1'b0;
    operand      = bin_in;
  end
`endif

  // Add-3 correction on every BCD digit >= 5, then shift left by one
  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[SrW-2:0], 1'b0};
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      sign_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
      sign_out  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            sr_q      <= {{BcdW{1'b0}}, operand};
            cnt_q     <= CntW'(BIN_W);
            ovf_acc_q <= 1'b0;
            sign_q    <= operand_sign;
            busy      <= 1'b1;
            state_q   <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          sr_q  <= sr_shift;
          cnt_q <= cnt_q - 1'b1;
          // A set MSB of the top digit is shifted out: value no longer fits
          ovf_acc_q <= ovf_acc_q | sr_adj[SrW-1];
          if (cnt_q == CntW'(1)) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd_out  <= sr_shift[SrW-1:BIN_W];
            ovf      <= ovf_acc_q | sr_adj[SrW-1];
            sign_out <= sign_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
